// File: rtl/tt_proj_mux_ctrl.sv
// Project mux controller: selects one of N_PROJ project slots and sequences
// the switch with a break-before-make gap, then a held project reset, then
// ACTIVE. Only the selected slot drives the pads, and only while ACTIVE.
module tt_proj_mux_ctrl #(
  parameter int unsigned N_PROJ  = 16,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned RST_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ctrl_ena,
  input  logic                      sel_inc,
  input  logic                      sel_clr,
  input  logic                      user_rst_n,
  input  logic [N_PROJ*24-1:0]      ow_all,
  output logic [N_PROJ-1:0]         ena,
  output logic                      proj_rst_n,
  output logic [7:0]                uo_out,
  output logic [7:0]                uio_out,
  output logic [7:0]                uio_oe,
  output logic [$clog2(N_PROJ)-1:0] cur_addr,
  output logic                      busy
);

  localparam int unsigned AW = $clog2(N_PROJ);
  // The counter holds the remaining cycles in the current phase minus one.
  localparam logic [7:0] GapLoad = 8'(GAP_CYC - 1);
  localparam logic [7:0] RstLoad = 8'(RST_CYC - 1);
  localparam logic [AW-1:0] LastAddr = AW'(N_PROJ - 1);

  typedef enum logic [1:0] {StOff, StGap, StPrst, StActive} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          trigger;
  logic [23:0]   sel_word;

  // State, address and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: address stepping, (re)trigger into GAP, phase countdown.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;

    // Address moves regardless of state; clear has priority over increment.
    if (sel_clr) begin
      addr_d = '0;
    end else if (sel_inc) begin
      addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
    end

    // Any address change while enabled restarts the sequence, so a slot's
    // enable is always separated from another slot's by at least one GAP.
    trigger = ctrl_ena && ((state_q == StOff) || sel_inc || sel_clr);

    if (!ctrl_ena) begin
      state_d = StOff;
      cnt_d   = '0;
    end else if (trigger) begin
      state_d = StGap;
      cnt_d   = GapLoad;
    end else begin
      case (state_q)
        StGap: begin
          if (cnt_q == 8'd0) begin
            state_d = StPrst;
            cnt_d   = RstLoad;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StPrst: begin
          if (cnt_q == 8'd0) begin
            state_d = StActive;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state and address registers.
  always_comb begin
    ena        = '0;
    proj_rst_n = 1'b0;
    busy       = 1'b0;
    uo_out     = '0;
    uio_out    = '0;
    uio_oe     = '0;
    sel_word   = ow_all[24*addr_q +: 24];
    case (state_q)
      StGap: begin
        busy = 1'b1;
      end
      StPrst: begin
        busy         = 1'b1;
        ena[addr_q]  = 1'b1;
      end
      StActive: begin
        ena[addr_q]                = 1'b1;
        proj_rst_n                 = user_rst_n;
        {uio_oe, uio_out, uo_out}  = sel_word;
      end
      default: ;
    endcase
  end

  assign cur_addr = addr_q;

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Bench for tt_proj_mux_ctrl: directed scenarios followed by random stimulus,
// all checked against a cycles-since-trigger reference model.
module tb_tt_proj_mux_ctrl;

  localparam int N  = 16;
  localparam int G  = 2;
  localparam int R  = 4;
  localparam int AW = $clog2(N);

  logic            clk;
  logic            rst_n;
  logic            ctrl_ena;
  logic            sel_inc;
  logic            sel_clr;
  logic            user_rst_n;
  logic [N*24-1:0] ow_all;
  logic [N-1:0]    ena;
  logic            proj_rst_n;
  logic [7:0]      uo_out;
  logic [7:0]      uio_out;
  logic [7:0]      uio_oe;
  logic [AW-1:0]   cur_addr;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference model: enabled flag, address, cycles elapsed since last trigger.
  bit       m_on;
  int       m_addr;
  int       m_t;
  logic [N-1:0] prev_ena;

  tt_proj_mux_ctrl #(
    .N_PROJ (N),
    .GAP_CYC(G),
    .RST_CYC(R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl_ena  (ctrl_ena),
    .sel_inc   (sel_inc),
    .sel_clr   (sel_clr),
    .user_rst_n(user_rst_n),
    .ow_all    (ow_all),
    .ena       (ena),
    .proj_rst_n(proj_rst_n),
    .uo_out    (uo_out),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe),
    .cur_addr  (cur_addr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on     = 1'b0;
    m_addr   = 0;
    m_t      = 0;
    prev_ena = '0;
  endtask

  task automatic model_edge(input bit e, input bit inc, input bit clr);
    bit trig;
    trig = e && (!m_on || inc || clr);
    if (clr) m_addr = 0;
    else if (inc) m_addr = (m_addr + 1) % N;
    if (!e) begin
      m_on = 1'b0;
      m_t  = 0;
    end else if (trig) begin
      m_on = 1'b1;
      m_t  = 1;
    end else if (m_on && m_t < 1000) begin
      m_t++;
    end
  endtask

  task automatic check_outputs(input string tag);
    bit gap, prst, act;
    logic [N-1:0] e_ena;
    logic [23:0]  e_pad;
    gap   = m_on && (m_t <= G);
    prst  = m_on && (m_t > G) && (m_t <= G + R);
    act   = m_on && (m_t > G + R);
    e_ena = (prst || act) ? (N'(1) << m_addr) : '0;
    e_pad = act ? ow_all[24*m_addr +: 24] : 24'h0;
    chk({tag, ".ena"}, 64'(ena), 64'(e_ena));
    chk({tag, ".busy"}, 64'(busy), 64'(gap || prst));
    chk({tag, ".proj_rst_n"}, 64'(proj_rst_n), 64'(act ? user_rst_n : 1'b0));
    chk({tag, ".pads"}, 64'({uio_oe, uio_out, uo_out}), 64'(e_pad));
    chk({tag, ".cur_addr"}, 64'(cur_addr), 64'(m_addr));
    chk({tag, ".onehot0"}, 64'($onehot0(ena)), 64'd1);
    chk({tag, ".no_overlap"},
        64'((prev_ena == '0) || (ena == '0) || (ena == prev_ena)), 64'd1);
    prev_ena = ena;
  endtask

  // Advance one clock: model sees the inputs present at the edge, check #1 later.
  task automatic step(input string tag);
    bit e, i, c;
    e = ctrl_ena;
    i = sel_inc;
    c = sel_clr;
    @(posedge clk);
    model_edge(e, i, c);
    #1;
    check_outputs(tag);
  endtask

  task automatic fill_ow();
    for (int s = 0; s < N; s++) ow_all[24*s +: 24] = 24'($urandom);
  endtask

  initial begin
    rst_n      = 1'b0;
    ctrl_ena   = 1'b0;
    sel_inc    = 1'b0;
    sel_clr    = 1'b0;
    user_rst_n = 1'b1;
    ow_all     = '0;
    fill_ow();
    model_reset();

    // Reset state.
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle");
    step("idle");

    // Power-up sequence with defaults.
    ctrl_ena = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      step("seq");
      if (cyc <= 2) begin
        chk("seq.gap_ena", 64'(ena), 64'h0);
        chk("seq.gap_busy", 64'(busy), 64'd1);
      end else if (cyc <= 6) begin
        chk("seq.prst_ena", 64'(ena), 64'h0001);
        chk("seq.prst_rst", 64'(proj_rst_n), 64'd0);
      end else begin
        chk("seq.act_rst", 64'(proj_rst_n), 64'd1);
        chk("seq.act_busy", 64'(busy), 64'd0);
        chk("seq.act_uo", 64'(uo_out), 64'(ow_all[7:0]));
      end
    end

    // Move to slot 3 and let it become ACTIVE.
    sel_inc = 1'b1;
    for (int k = 0; k < 3; k++) step("to3");
    sel_inc = 1'b0;
    for (int k = 0; k < 8; k++) step("to3_settle");
    chk("to3.addr", 64'(cur_addr), 64'd3);

    // Single increment from ACTIVE at slot 3.
    sel_inc = 1'b1;
    step("inc4");
    sel_inc = 1'b0;
    chk("inc4.ena_off", 64'(ena), 64'h0);
    chk("inc4.pads_off", 64'({uio_oe, uio_out, uo_out}), 64'h0);
    step("inc4");
    step("inc4");
    chk("inc4.ena_on", 64'(ena), 64'h0010);
    for (int k = 0; k < 4; k++) step("inc4");
    chk("inc4.active_busy", 64'(busy), 64'd0);
    chk("inc4.active_pads", 64'({uio_oe, uio_out, uo_out}), 64'(ow_all[24*4 +: 24]));

    // Wrap 15 -> 0, and clear beats increment.
    sel_inc = 1'b1;
    for (int k = 0; k < 11; k++) step("wrap");
    chk("wrap.at15", 64'(cur_addr), 64'd15);
    step("wrap");
    chk("wrap.to0", 64'(cur_addr), 64'd0);
    for (int k = 0; k < 5; k++) step("to5");
    chk("to5.addr", 64'(cur_addr), 64'd5);
    sel_clr = 1'b1;
    step("clr_wins");
    sel_clr = 1'b0;
    sel_inc = 1'b0;
    chk("clr_wins.addr", 64'(cur_addr), 64'd0);
    for (int k = 0; k < 8; k++) step("settle0");

    // Increment during PRST restarts a full sequence.
    sel_inc = 1'b1;
    step("prst_inc");
    sel_inc = 1'b0;
    step("prst_inc");
    step("prst_inc");
    chk("prst_inc.slot1", 64'(ena), 64'h0002);
    sel_inc = 1'b1;
    step("prst_inc");
    sel_inc = 1'b0;
    chk("prst_inc.drop", 64'(ena), 64'h0);
    for (int k = 2; k <= 7; k++) begin
      step("prst_inc");
      if (k == 2) chk("prst_inc.gap2", 64'(busy), 64'd1);
      if (k == 3) chk("prst_inc.slot2", 64'(ena), 64'h0004);
    end
    chk("prst_inc.active", 64'(busy), 64'd0);

    // Disable during ACTIVE, then step the address while OFF.
    ctrl_ena = 1'b0;
    step("off");
    chk("off.ena", 64'(ena), 64'h0);
    chk("off.rst", 64'(proj_rst_n), 64'd0);
    chk("off.oe", 64'(uio_oe), 64'h0);
    sel_inc = 1'b1;
    for (int k = 0; k < 3; k++) step("off_inc");
    sel_inc = 1'b0;
    chk("off_inc.addr", 64'(cur_addr), 64'd5);
    chk("off_inc.ena", 64'(ena), 64'h0);

    // Asynchronous reset in the middle of PRST.
    ctrl_ena = 1'b1;
    for (int k = 0; k < 3; k++) step("pre_arst");
    chk("pre_arst.prst", 64'(ena), 64'h0020);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.ena", 64'(ena), 64'h0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.rst", 64'(proj_rst_n), 64'd0);
    chk("arst.pads", 64'({uio_oe, uio_out, uo_out}), 64'h0);
    chk("arst.addr", 64'(cur_addr), 64'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step("post_arst");
    chk("post_arst.prst", 64'(ena), 64'h0001);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      ctrl_ena   = ($urandom_range(0, 19) != 0);
      sel_inc    = ($urandom_range(0, 9) == 0);
      sel_clr    = ($urandom_range(0, 24) == 0);
      user_rst_n = 1'($urandom_range(0, 1));
      if ((k % 64) == 0) fill_ow();
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_proj_mux_ctrl.md
TT_PROJ_MUX_CTRL -- requirements
Module: tt_proj_mux_ctrl

Interface
REQ-001 SHALL have parameter N_PROJ, default 16: number of project wrapper slots (2..64).
REQ-002 SHALL have parameter GAP_CYC, default 2: break-before-make cycles with all slots disabled (1..255).
REQ-003 SHALL have parameter RST_CYC, default 4: cycles the selected slot is held in reset after enable (1..255).
REQ-004 SHALL have clk, input, 1: single clock; the same clk is forwarded to the projects.
REQ-005 SHALL have rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ctrl_ena, input, 1: level; 1 = a project is to be active.
REQ-007 SHALL have sel_inc, input, 1: single-cycle pulse; advance the slot address.
REQ-008 SHALL have sel_clr, input, 1: single-cycle pulse; set the slot address to 0.
REQ-009 SHALL have user_rst_n, input, 1: pad-level project reset, passed through in ACTIVE.
REQ-010 SHALL have ow_all, input, N_PROJ*24: per-slot {uio_oe, uio_out, uo_out}; slot i at bits [24*i +: 24].
REQ-011 SHALL have ena, output, N_PROJ: one-hot or all-zero slot enables.
REQ-012 SHALL have proj_rst_n, output, 1: reset driven to the projects.
REQ-013 SHALL have uo_out, output, 8; uio_out, output, 8; uio_oe, output, 8: outputs of the selected slot.
REQ-014 SHALL have cur_addr, output, clog2(N_PROJ): current slot address.
REQ-015 SHALL have busy, output, 1: high in the GAP and PRST states.

Function
REQ-016 SHALL implement the states OFF, GAP, PRST and ACTIVE, with an 8-bit down-counter.
REQ-017 SHALL, on sel_inc, set addr to addr+1, wrapping from N_PROJ-1 to 0; sel_clr SHALL set addr to 0; if both are asserted in one cycle, sel_clr wins.
REQ-018 SHALL define a trigger as any cycle, sampled at the clock edge, in which ctrl_ena=1 and either the state is OFF or sel_inc/sel_clr is asserted.
REQ-019 SHALL, on a trigger sampled at edge 0, occupy GAP during cycles 1..GAP_CYC, PRST during cycles GAP_CYC+1..GAP_CYC+RST_CYC, and ACTIVE from cycle GAP_CYC+RST_CYC+1.
REQ-020 SHALL restart at GAP with a fresh count when a trigger occurs in GAP, PRST or ACTIVE; the new address applies.
REQ-021 SHALL enter OFF on the edge after ctrl_ena is sampled 0, from any state, with no GAP.
REQ-022 SHALL update addr on sel_inc/sel_clr while in OFF without leaving OFF.
REQ-023 SHALL drive ena = one-hot(addr) in PRST and ACTIVE, and all-zero in OFF and GAP; ena is decoded from the state register and addr register only (Moore).
REQ-024 SHALL drive proj_rst_n = 0 in OFF, GAP and PRST, and proj_rst_n = user_rst_n in ACTIVE.
REQ-025 SHALL drive {uio_oe, uio_out, uo_out} = ow_all[24*addr +: 24] in ACTIVE, and all zeros otherwise, so pads are tristated during switching.
REQ-026 SHALL guarantee that ena never has more than one bit set and that no slot's ena bit is high in the cycle immediately after a different slot's bit was high.
REQ-027 SHALL drive busy = 1 exactly in GAP and PRST.
REQ-028 SHALL keep cur_addr = addr at all times.

Reset
REQ-029 SHALL, with rst_n low, asynchronously force: state OFF, addr 0, counter 0, ena 0, proj_rst_n 0, busy 0, uo_out/uio_out/uio_oe 0.
REQ-030 SHALL, when rst_n is asserted mid-sequence (GAP, PRST or ACTIVE), force OFF immediately; after release with ctrl_ena=1, a normal trigger from OFF occurs at the first edge.

Verification
REQ-031 SHALL check: reset release, then ctrl_ena=1 at edge 0 with defaults -> cycles 1-2 ena=0, busy=1; cycles 3-6 ena=0x0001, proj_rst_n=0; cycle 7 onward proj_rst_n=user_rst_n, busy=0, uo_out=ow_all[7:0].
REQ-032 SHALL check: ACTIVE at addr 3, one sel_inc pulse -> next cycle ena=0 and outputs 0; 2 cycles later ena=0x0010; ACTIVE at addr 4 after 4 more cycles.
REQ-033 SHALL check: addr=15 (N_PROJ=16) then sel_inc -> addr=0; sel_inc and sel_clr in the same cycle at addr 5 -> addr=0.
REQ-034 SHALL check: sel_inc during PRST -> ena drops to 0 next cycle, a full GAP+PRST for the new address follows, and no cycle has two ena bits set.
REQ-035 SHALL check: ctrl_ena=0 during ACTIVE -> next cycle ena=0, proj_rst_n=0, uio_oe=0; sel_inc pulses x3 while OFF -> cur_addr advances by 3 with ena remaining 0.
REQ-036 SHALL check: rst_n asserted asynchronously mid-PRST -> all outputs 0 before the next clock edge; cur_addr=0.
